rx_demux_lane_sched: RTL and testbench

//  Scheduler/sequencer for the Rx 1:2 byte demux stage. Accepts one byte stream at clk_2f and

---
 rtl/rx_demux_lane_sched_pkg.sv | 6 +
 rtl/rx_demux_lane_sched_out_reg.sv | 36 +++
 rtl/rx_demux_lane_sched.sv | 80 ++++++++
 tb/tb_rx_demux_lane_sched.sv | 131 +++++++++++++
 4 files changed

// File: rtl/rx_demux_lane_sched_pkg.sv
// rx_demux_lane_sched_pkg: shared state encoding and lane identifiers for the Rx 1:2 demux scheduler
package rx_demux_lane_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STALL = 2'd2} state_e;
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;
endpackage

// File: rtl/rx_demux_lane_sched_out_reg.sv
// rx_demux_lane_sched_out_reg: per-lane output byte register, one-cycle valid pulse and wrapping byte counter
module rx_demux_lane_sched_out_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  cnt
);
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  always_comb begin
    data_d  = load ? data : data_q;
    cnt_d   = cnt_q + CNT_W'(load);
    valid_d = load;
  end
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign cnt       = cnt_q;
endmodule

// File: rtl/rx_demux_lane_sched.sv
// rx_demux_lane_sched: steers a byte stream to two lanes in strict alternation with per-lane backpressure
module rx_demux_lane_sched
  import rx_demux_lane_sched_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int IDLE_TIMEOUT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  input  logic              ready0,
  input  logic              ready1,
  output logic              validout0,
  output logic              validout1,
  output logic [DATA_W-1:0] dataout0,
  output logic [DATA_W-1:0] dataout1,
  output logic              lane_sel,
  output logic              busy,
  output logic              overflow_err,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  state_e            state_q, state_d;
  logic              lane_sel_q, lane_sel_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              ovf_q, ovf_d;
  logic              stall, rdy, go, ld0, ld1;
  logic [DATA_W-1:0] ld_data;
  always_comb begin
    stall      = state_q == ST_STALL;
    rdy        = lane_sel_q ? ready1 : ready0;
    go         = rdy && (stall || valid);
    ld_data    = stall ? hold_q : data_in;
    ld0        = go && lane_sel_q == LANE0;
    ld1        = go && lane_sel_q == LANE1;
    ovf_d      = ovf_q || (valid && stall);
    hold_d     = (!stall && valid && !rdy) ? data_in : hold_q;
    lane_sel_d = go ? ~lane_sel_q : lane_sel_q;
    state_d    = go ? ST_RUN : (!stall && valid) ? ST_STALL : state_q;
    idle_d     = (state_q == ST_RUN && !valid) ? idle_q + IW'(1) : '0;
    // Timeout only fires on a valid-low cycle, so a coincident valid always wins
    if (idle_d == IW'(IDLE_TIMEOUT)) begin
      state_d    = ST_IDLE;
      lane_sel_d = LANE0;
      idle_d     = '0;
    end
  end
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lane_sel_q <= LANE0;
      hold_q     <= '0;
      idle_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_sel_q <= lane_sel_d;
      hold_q     <= hold_d;
      idle_q     <= idle_d;
      ovf_q      <= ovf_d;
    end
  end
  rx_demux_lane_sched_out_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane0 (
    .clk_2f(clk_2f), .reset(reset), .load(ld0), .data(ld_data),
    .valid_out(validout0), .data_out(dataout0), .cnt(cnt0)
  );
  rx_demux_lane_sched_out_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane1 (
    .clk_2f(clk_2f), .reset(reset), .load(ld1), .data(ld_data),
    .valid_out(validout1), .data_out(dataout1), .cnt(cnt1)
  );
  assign in_ready     = !stall;
  assign busy         = state_q != ST_IDLE;
  assign lane_sel     = lane_sel_q;
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_rx_demux_lane_sched.sv
// tb_rx_demux_lane_sched: directed self-checking bench for the Rx 1:2 demux scheduler
module tb_rx_demux_lane_sched;
  logic        clk_2f = 1'b0;
  logic        reset, valid, ready0, ready1;
  logic [7:0]  data_in;
  logic        in_ready, validout0, validout1, lane_sel, busy, overflow_err;
  logic [7:0]  dataout0, dataout1;
  logic [15:0] cnt0, cnt1;
  logic        w_valid, w_in_ready, w_v0, w_v1, w_lane_sel, w_busy, w_ovf;
  logic [7:0]  w_data, w_d0, w_d1;
  logic [3:0]  w_cnt0, w_cnt1;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk_2f = ~clk_2f;
  rx_demux_lane_sched u_dut (
    .clk_2f(clk_2f), .reset(reset), .valid(valid), .data_in(data_in), .in_ready(in_ready),
    .ready0(ready0), .ready1(ready1), .validout0(validout0), .validout1(validout1),
    .dataout0(dataout0), .dataout1(dataout1), .lane_sel(lane_sel), .busy(busy),
    .overflow_err(overflow_err), .cnt0(cnt0), .cnt1(cnt1)
  );
  rx_demux_lane_sched #(.CNT_W(4)) u_wrap (
    .clk_2f(clk_2f), .reset(reset), .valid(w_valid), .data_in(w_data), .in_ready(w_in_ready),
    .ready0(1'b1), .ready1(1'b1), .validout0(w_v0), .validout1(w_v1),
    .dataout0(w_d0), .dataout1(w_d1), .lane_sel(w_lane_sel), .busy(w_busy),
    .overflow_err(w_ovf), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    valid = 1'b1;
    data_in = b;
    tick();
    valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1; valid = 1'b0; data_in = '0; ready0 = 1'b1; ready1 = 1'b1;
    w_valid = 1'b0; w_data = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1); check("rst_busy", busy, 0);
    check("rst_lane_sel", lane_sel, 0); check("rst_vout", {validout1, validout0}, 0);
    check("rst_data", {dataout1, dataout0}, 0); check("rst_cnt", {cnt1, cnt0}, 0);
    check("rst_ovf", overflow_err, 0);
    // 1) back-to-back alternation, 1-cycle latency
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      data_in = 8'hA0 + 8'(i);
      tick();
      check("t1_vout", {validout1, validout0}, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("t1_data", (i % 2 == 0) ? dataout0 : dataout1, 8'hA0 + i);
    end
    valid = 1'b0;
    tick();
    check("t1_vout_idle", {validout1, validout0}, 0);
    check("t1_cnt0", cnt0, 3); check("t1_cnt1", cnt1, 3); check("t1_lane_sel", lane_sel, 0);
    // 2) lane 1 stalls for 3 cycles
    send(8'hB0);
    check("t2_b0", {validout0, dataout0}, {1'b1, 8'hB0});
    ready1 = 1'b0;
    send(8'hB1);
    check("t2_stall_rdy", in_ready, 0); check("t2_stall_vout", {validout1, validout0}, 0);
    tick(); check("t2_stall_rdy2", in_ready, 0);
    tick(); check("t2_stall_rdy3", in_ready, 0);
    ready1 = 1'b1;
    tick();
    check("t2_b1", {validout1, dataout1}, {1'b1, 8'hB1});
    check("t2_in_ready", in_ready, 1); check("t2_lane_sel", lane_sel, 0);
    send(8'hB2);
    check("t2_b2", {validout0, validout1, dataout0}, {2'b10, 8'hB2});
    check("t2_ovf", overflow_err, 0);
    // 3) byte presented during stall is dropped
    ready1 = 1'b0;
    send(8'hB3);
    send(8'hEE);
    check("t3_ovf", overflow_err, 1); check("t3_vout", {validout1, validout0}, 0);
    ready1 = 1'b1;
    tick();
    check("t3_b3", {validout1, dataout1}, {1'b1, 8'hB3});
    check("t3_d0", dataout0, 8'hB2);
    tick();
    check("t3_vout_after", {validout1, validout0}, 0);
    check("t3_cnts", {cnt1, cnt0}, {16'd5, 16'd5});
    // 4) idle gap realigns phase to lane 0
    send(8'h31); send(8'h32); send(8'h33);
    check("t4_lane_sel1", lane_sel, 1);
    tick(); tick(); tick();
    check("t4_busy_pre", {busy, lane_sel}, 2'b11);
    tick();
    check("t4_busy_post", {busy, lane_sel}, 2'b00);
    send(8'hC0);
    check("t4_c0", {validout0, validout1, dataout0}, {2'b10, 8'hC0});
    check("t4_ovf_sticky", overflow_err, 1);
    // 5) reset while holding a byte
    ready1 = 1'b0;
    send(8'hD1);
    check("t5_stall", in_ready, 0);
    reset = 1'b1;
    ready1 = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_vout", {validout1, validout0}, 0);
    check("t5_state", {in_ready, busy, lane_sel, overflow_err}, 4'b1000);
    check("t5_data", {dataout1, dataout0}, 0); check("t5_cnt", {cnt1, cnt0}, 0);
    tick();
    check("t5_vout_late", {validout1, validout0}, 0);
    send(8'h55);
    check("t5_first", {validout0, validout1, dataout0}, {2'b10, 8'h55});
    // 6) 4-bit counter wrap: 33 bytes -> 17 on lane 0, 16 on lane 1
    for (int i = 0; i < 33; i++) begin
      w_valid = 1'b1;
      w_data = 8'(i);
      tick();
      if (i == 31) check("t6_wrap32", {w_cnt1, w_cnt0}, 8'h00);
    end
    w_valid = 1'b0;
    tick();
    check("t6_cnt0", w_cnt0, 1); check("t6_cnt1", w_cnt1, 0);
    check("t6_last", w_d0, 8'd32);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
